z_core_icache_sa: RTL and testbench
===================================

Name: z_core_icache_sa

Overview:
Set-associative, multi-word-line instruction cache for the Z-Core fetch stage. It keeps the single-cycle combinational hit path used in the fetch stage. On a miss it refills the line autonomously from the memory interface using a burst FSM. It also supports a sequential full-cache invalidate (fence.i flush). It sits between the fetch unit and the instruction-memory bus master.

Parameters:
DATA_WIDTH, 32, instruction/word width in bits (multiple of 8)
ADDR_WIDTH, 32, byte address width
NUM_SETS, 64, number of sets (power of 2, >=2)
NUM_WAYS, 2, associativity (1, 2 or 4)
LINE_WORDS, 4, words per line (power of 2, >=1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous active-high reset
req_valid  in  1  fetch request present; req_addr held stable until resp_valid
req_addr  in  ADDR_WIDTH  byte address of fetch (word aligned)
resp_valid  out  1  combinational hit: data valid this cycle
resp_data  out  DATA_WIDTH  combinational word from the hitting way; 0 when no hit
stall  out  1  req_valid & !resp_valid
flush  in  1  single-cycle pulse: invalidate all lines
flush_busy  out  1  high while the flush is pending or in progress
mem_req_valid  out  1  line refill request
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  ADDR_WIDTH  line-aligned byte address (low offset bits zero)
mem_resp_valid  in  1  one refill beat
mem_resp_data  in  DATA_WIDTH  refill word; beats arrive in ascending word order

Behaviour:
- Address split, LSB first: byte offset log2(DATA_WIDTH/8); word offset log2(LINE_WORDS); index log2(NUM_SETS); tag is the remaining upper bits. With defaults: word = addr[3:2], index = addr[9:4], tag = addr[31:10].
- Storage per way per set: valid bit, tag, LINE_WORDS data words. Each set also has a victim pointer of log2(NUM_WAYS) bits.
- Reset (async, rst=1) clears:
  - all valid bits and victim pointers;
  - state goes to IDLE;
  - resp_valid=0, resp_data=0, stall=0, mem_req_valid=0, mem_req_addr=0, flush_busy=0.
  - Data arrays are not cleared.
- Hit: resp_valid = (state==IDLE) & req_valid & any way in the set with valid & tag match. This is purely combinational, with zero latency and no clock edge needed. At most one way can match.
- FSM states: IDLE, REQ, FILL, FLUSH.
- IDLE:
  - On req_valid & miss & no pending flush: latch the line address and victim way, then go to REQ.
  - On a flush pulse or latched flush: go to FLUSH with the set counter at 0.
  - Flush has priority over a miss.
- REQ: mem_req_valid=1 and mem_req_addr = latched line address, held stable. On mem_req_ready go to FILL with the beat counter at 0.
- FILL:
  - Each mem_resp_valid writes mem_resp_data into the victim way at word = beat counter, then increments the counter.
  - On the last beat (counter==LINE_WORDS-1), in the same edge: write the tag, set valid, advance the set's victim pointer (wraps at NUM_WAYS-1), go to IDLE.
  - The request hits on the following cycle, so miss-to-data latency is 1 + request-wait + LINE_WORDS + 1 cycles.
- Victim selection: the lowest-numbered invalid way; if none is invalid, the set's victim pointer. The pointer advances only when a valid line is replaced.
- The valid bit of the victim way is cleared on entry to REQ. A partially filled line never hits.
- FLUSH: clears valid for all ways of set[counter] each cycle and resets that set's victim pointer. Takes exactly NUM_SETS cycles, then goes to IDLE. flush_busy=1 throughout. resp_valid=0 and stall=req_valid during the flush.
- A flush arriving during REQ/FILL is latched (flush_busy=1 immediately). It starts after the refill completes, so the refilled line is invalidated.
- A flush pulse during FLUSH is absorbed; the flush does not restart.
- mem_resp_valid outside FILL is ignored.
- Reset asserted mid-REQ/FILL/FLUSH aborts immediately: mem_req_valid drops and all lines become invalid. Late refill beats are ignored.
- req_addr changing during REQ/FILL is a protocol violation; the refill completes for the latched address.

Test Plan:
- Reset, then req 0x1000 -> resp_valid=0, stall=1; mem_req_addr=0x1000; after ready and 4 beats 0xA0..0xA3, next cycle resp_data=0xA0; then addr 0x100C -> hit 0xA3 with no clock edge.
- Fill 0x1000 and 0x1400 (same set 0, tags differ) -> both hit with 2 ways. Request 0x1800 -> refill evicts way 0 (0x1000 misses, 0x1400 still hits). Request 0x1C00 -> evicts way 1.
- Hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stable; no beats accepted; resp_valid=0 throughout.
- Fill 3 lines, then pulse flush -> flush_busy=1 for exactly 64 cycles; all previous addresses miss afterwards.
- Pulse flush during FILL beat 2 -> refill completes; flush runs immediately after; the refilled address misses.
- Assert rst during FILL beat 1 -> mem_req_valid=0 immediately, extra beats ignored; the address misses and its refill restarts cleanly.

Source files
------------

// File: rtl/z_core_icache_sa.sv
// Set-associative instruction cache with a combinational hit path, an autonomous
// burst refill FSM and a sequential whole-cache invalidate.
module z_core_icache_sa #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  stall,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);
    localparam int BO = $clog2(DATA_WIDTH / 8);
    localparam int WO = $clog2(LINE_WORDS);
    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = ADDR_WIDTH - BO - WO - IW;
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int CW = (LINE_WORDS > 1) ? WO : 1;

    typedef enum logic [1:0] {IDLE, REQ, FILL, FLUSH} state_t;
    state_t state;

    logic [NUM_SETS-1:0]   valid    [NUM_WAYS];
    logic [TW-1:0]         tag_mem  [NUM_WAYS][NUM_SETS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_WAYS][NUM_SETS][LINE_WORDS];
    logic [WW-1:0]         vptr     [NUM_SETS];

    logic [ADDR_WIDTH-1:0] line_addr;
    logic [WW-1:0]         fill_way;
    logic                  fill_repl;
    logic [CW-1:0]         beat;
    logic [IW-1:0]         fcnt;
    logic                  flush_pend;

    logic [IW-1:0] req_idx, fill_idx;
    logic [TW-1:0] req_tag, fill_tag;
    logic [CW-1:0] req_word;
    logic          hit, victim_repl, last_beat;
    logic [WW-1:0] hit_way, victim;

    // Shifts instead of part-selects keep LINE_WORDS=1 (zero-width offset) legal.
    assign req_idx   = IW'(req_addr >> (BO + WO));
    assign req_tag   = TW'(req_addr >> (BO + WO + IW));
    assign req_word  = CW'((req_addr >> BO) & ADDR_WIDTH'(LINE_WORDS - 1));
    assign fill_idx  = IW'(line_addr >> (BO + WO));
    assign fill_tag  = TW'(line_addr >> (BO + WO + IW));
    assign last_beat = (state == FILL) && mem_resp_valid && (beat == CW'(LINE_WORDS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Lowest invalid way wins; only a full set falls back to the rotating pointer.
    always_comb begin
        victim      = vptr[req_idx];
        victim_repl = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[w][req_idx]) begin
                victim      = WW'(w);
                victim_repl = 1'b0;
            end
        end
    end

    assign resp_valid    = (state == IDLE) && req_valid && hit;
    assign resp_data     = resp_valid ? data_mem[hit_way][req_idx][req_word] : '0;
    assign stall         = req_valid && !resp_valid;
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = line_addr;
    assign flush_busy    = (state == FLUSH) || flush_pend;

    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_resp_valid)
            data_mem[fill_way][fill_idx][beat] <= mem_resp_data;
        if (last_beat)
            tag_mem[fill_way][fill_idx] <= fill_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            line_addr  <= '0;
            fill_way   <= '0;
            fill_repl  <= 1'b0;
            beat       <= '0;
            fcnt       <= '0;
            for (int w = 0; w < NUM_WAYS; w++) valid[w] <= '0;
            for (int s = 0; s < NUM_SETS; s++) vptr[s] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        state      <= FLUSH;
                        fcnt       <= '0;
                        flush_pend <= 1'b0;
                    end else if (req_valid && !hit) begin
                        line_addr              <= (req_addr >> (BO + WO)) << (BO + WO);
                        fill_way               <= victim;
                        fill_repl              <= victim_repl;
                        valid[victim][req_idx] <= 1'b0;
                        state                  <= REQ;
                    end
                end
                REQ: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_req_ready) begin
                        state <= FILL;
                        beat  <= '0;
                    end
                end
                FILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_resp_valid) beat <= beat + 1'b1;
                    if (last_beat) begin
                        valid[fill_way][fill_idx] <= 1'b1;
                        if (fill_repl)
                            vptr[fill_idx] <= (vptr[fill_idx] == WW'(NUM_WAYS - 1)) ? '0 : vptr[fill_idx] + 1'b1;
                        // A flush that arrived mid-refill starts straight away so the new line never hits.
                        if (flush || flush_pend) begin
                            state      <= FLUSH;
                            fcnt       <= '0;
                            flush_pend <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    for (int w = 0; w < NUM_WAYS; w++) valid[w][fcnt] <= 1'b0;
                    vptr[fcnt] <= '0;
                    fcnt       <= fcnt + 1'b1;
                    if (fcnt == IW'(NUM_SETS - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_z_core_icache_sa.sv
// Scoreboard bench: driver pushes expected words, monitor pops on resp_valid;
// a residency model (tags per set) predicts hits and an ideal memory supplies data.
module tb_z_core_icache_sa;
    localparam int LW = 4;

    logic        clk = 1'b0, rst = 1'b0, req_valid = 1'b0, flush = 1'b0;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [31:0] req_addr = '0, mem_resp_data = '0;
    logic        resp_valid, stall, flush_busy, mem_req_valid;
    logic [31:0] resp_data, mem_req_addr;

    int checks = 0, failures = 0;

    z_core_icache_sa dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .stall(stall),
        .flush(flush), .flush_busy(flush_busy),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    // Residency model: which tags live in which set, plus the replacement pointer.
    bit          m_valid [64][2];
    logic [21:0] m_tag   [64][2];
    int          m_ptr   [64];
    logic [31:0] exp_q[$];
    logic [31:0] cur_line = '0;
    logic [31:0] la = '0;
    int rand_ready = 0, gap_en = 0, ready_hold = 0, mem_hs = 0, drv_idx = -1, beats_left = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h1010) return 32'hA0 + ((a - 32'h1000) >> 2);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s;
        s = int'(a[9:4]);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:10]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_install(input logic [31:0] a);
        int s, v;
        s = int'(a[9:4]);
        v = -1;
        for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) begin
            v = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % 2;
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = a[31:10];
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < 64; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acts at posedge+1, the handshake lands on the following edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            drv_idx = -1;
            if (beats_left > 0 && (gap_en == 0 || $urandom_range(0, 3) != 0)) begin
                drv_idx        = LW - beats_left;
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_rd(la + 32'(4 * drv_idx));
                beats_left--;
            end
            if (ready_hold > 0 && mem_req_valid) begin
                mem_req_ready = 1'b0;
                ready_hold--;
            end else begin
                mem_req_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (mem_req_valid && mem_req_ready) begin
                la = mem_req_addr;
                beats_left = LW;
                mem_hs++;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the cache answers a request.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req_valid) begin
                    chk("mem_req_addr", mem_req_addr, cur_line);
                    chk("no_resp_in_req", 32'(resp_valid), 32'd0);
                end
                if (req_valid && resp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp: data %h with nothing expected", resp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_data", resp_data, e);
                    end
                end
            end
        end
    end

    // ev_kind: 0 none, 1 flush pulse, 2 reset pulse, fired while refill beat ev_beat is on the bus.
    task automatic fetch(input logic [31:0] a, input int miss_lat, input int ev_kind, input int ev_beat);
        bit hexp, ev_done, fb_pend;
        int cyc, hs0, rst_hold;
        @(posedge clk); #2;
        hexp = m_hit(a);
        cur_line = {a[31:4], 4'h0};
        exp_q.push_back(mem_rd(a));
        hs0 = mem_hs;
        ev_done = 1'b0;
        fb_pend = 1'b0;
        rst_hold = 0;
        req_addr = a;
        req_valid = 1'b1;
        #1;
        chk("hit_now", 32'(resp_valid), 32'(hexp));
        chk("stall_now", 32'(stall), 32'(!hexp));
        cyc = 0;
        while (!resp_valid && cyc < 300) begin
            @(posedge clk); #2;
            cyc++;
            flush = 1'b0;
            if (fb_pend) begin
                chk("flush_busy_latched", 32'(flush_busy), 32'd1);
                fb_pend = 1'b0;
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b0;
            end
            if (ev_kind != 0 && !ev_done && mem_resp_valid && drv_idx == ev_beat) begin
                ev_done = 1'b1;
                if (ev_kind == 1) begin
                    flush = 1'b1;
                    fb_pend = 1'b1;
                end else begin
                    rst = 1'b1;
                    #1;
                    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
                    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
                    chk("rst_flush_busy", 32'(flush_busy), 32'd0);
                    m_clear();
                    rst_hold = 2;
                end
            end
        end
        flush = 1'b0;
        if (!resp_valid) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout: addr %h no resp_valid after %0d cycles", a, cyc);
            void'(exp_q.pop_back());
        end else if (!hexp && miss_lat >= 0) begin
            chk("miss_latency", 32'(cyc), 32'(miss_lat));
        end
        chk("refill_requests", 32'(mem_hs - hs0), (ev_kind != 0) ? 32'd2 : (hexp ? 32'd0 : 32'd1));
        if (ev_kind == 1) m_clear();
        if (!hexp) m_install(a);
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic do_flush();
        int n;
        @(posedge clk); #2;
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!flush_busy) break;
            n++;
        end
        chk("flush_cycles", 32'(n), 32'd64);
        m_clear();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        m_clear();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_req_addr", mem_req_addr, 32'd0);
        chk("rst_flush_busy", 32'(flush_busy), 32'd0);
        rst = 1'b0;

        // Directed: first refill, same-line hit, way eviction order.
        fetch(32'h1000, 6, 0, 0);
        fetch(32'h100C, 6, 0, 0);
        fetch(32'h1400, 6, 0, 0);
        fetch(32'h1000, 6, 0, 0);
        fetch(32'h1404, 6, 0, 0);
        fetch(32'h1800, 6, 0, 0);
        fetch(32'h1400, 6, 0, 0);
        fetch(32'h1C00, 6, 0, 0);
        fetch(32'h1800, 6, 0, 0);
        fetch(32'h1008, 6, 0, 0);
        fetch(32'h1400, 6, 0, 0);

        // Memory withholds ready for five REQ cycles.
        ready_hold = 5;
        fetch(32'h2000, 11, 0, 0);

        // Full flush after three resident lines.
        fetch(32'h3010, 6, 0, 0);
        fetch(32'h3020, 6, 0, 0);
        fetch(32'h3030, 6, 0, 0);
        do_flush();
        fetch(32'h3010, 6, 0, 0);
        fetch(32'h3020, 6, 0, 0);
        fetch(32'h2000, 6, 0, 0);

        // Flush during beat 2, reset during beat 1.
        fetch(32'h4040, -1, 1, 2);
        fetch(32'h4044, 6, 0, 0);
        fetch(32'h5050, -1, 2, 1);
        fetch(32'h3010, 6, 0, 0);
        fetch(32'h5054, 6, 0, 0);

        // Randomized traffic with a backpressured, gappy memory.
        rand_ready = 1;
        gap_en = 1;
        for (int i = 0; i < 90; i++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'h0001_0000;
            if ($urandom_range(0, 24) == 0) do_flush();
            else if (i % 13 == 7 && !m_hit(a)) fetch(a, -1, 1, int'($urandom_range(0, 3)));
            else fetch(a, -1, 0, 0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
